// File: rtl/dpram_pkg.sv
// Shared widths and read-side FSM encoding for the dual-port-RAM FIFO.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dpram_pkg;

    localparam int DPRAM_DATA_W = 8;
    localparam int DPRAM_ADDR_W = 4;

    // IDLE: nothing in flight, FETCH: RAM read in flight, HOLD: out_data valid
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } rd_state_t;

endpackage

// File: rtl/dpram_fifo.sv
// Complete FIFO: dpram_fifo_ctrl driving a dualport_withconflict RAM.
// Latency: push to out_valid 3 cycles; at most one pop every 2 cycles.
// Backpressure: in_ready low when full or flushing; ram_conflict reports
// any same-address access on both RAM ports (never expected).
module dpram_fifo
    import dpram_pkg::*;
#(
    parameter int DATA_W = DPRAM_DATA_W,
    parameter int ADDR_W = DPRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [ADDR_W:0]   ram_level,
    output logic              ram_conflict
);

    logic [ADDR_W-1:0] addr_a;
    logic              write_a;
    logic [DATA_W-1:0] write_data_a;
    logic              read_a;
    logic [DATA_W-1:0] unused_read_data_a;
    logic [ADDR_W-1:0] addr_b;
    logic              read_b;
    logic              write_b;
    logic [DATA_W-1:0] write_data_b;
    logic [DATA_W-1:0] read_data_b;

    dpram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ctrl (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_ready        (out_ready),
        .ram_level        (ram_level),
        .ram_addr_a       (addr_a),
        .ram_write_a      (write_a),
        .ram_write_data_a (write_data_a),
        .ram_read_a       (read_a),
        .ram_addr_b       (addr_b),
        .ram_read_b       (read_b),
        .ram_write_b      (write_b),
        .ram_write_data_b (write_data_b),
        .ram_read_data_b  (read_data_b)
    );

    dualport_withconflict #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk          (clk),
        .addr_a       (addr_a),
        .write_a      (write_a),
        .write_data_a (write_data_a),
        .read_a       (read_a),
        .read_data_a  (unused_read_data_a),
        .addr_b       (addr_b),
        .write_b      (write_b),
        .write_data_b (write_data_b),
        .read_b       (read_b),
        .read_data_b  (read_data_b),
        .conflict     (ram_conflict)
    );

endmodule

// File: rtl/dualport_withconflict.sv
// Two-port RAM, registered reads, both ports may read or write.
// Latency: read data valid the cycle after read is sampled high.
// Backpressure: none; same-address access on both ports raises conflict
// (port A write wins, a read forwards the other port's write data).
// Ports: clk; per port addr/write/write_data/read/read_data; conflict flag.
module dualport_withconflict
    import dpram_pkg::*;
#(
    parameter int DATA_W = DPRAM_DATA_W,
    parameter int ADDR_W = DPRAM_ADDR_W
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic              write_a,
    input  logic [DATA_W-1:0] write_data_a,
    input  logic              read_a,
    output logic [DATA_W-1:0] read_data_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic              write_b,
    input  logic [DATA_W-1:0] write_data_b,
    input  logic              read_b,
    output logic [DATA_W-1:0] read_data_b,
    output logic              conflict
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic              same_addr;

    assign same_addr = (addr_a == addr_b);
    assign conflict  = same_addr && (write_a || read_a) && (write_b || read_b);

    // No reset on the array: stale contents are unreachable once the
    // controller's pointers are cleared.
    always_ff @(posedge clk) begin
        if (write_a) begin
            mem[addr_a] <= write_data_a;
        end
        if (write_b && !(write_a && same_addr)) begin
            mem[addr_b] <= write_data_b;
        end
        if (read_a) begin
            read_data_a <= (write_b && same_addr) ? write_data_b : mem[addr_a];
        end
        if (read_b) begin
            read_data_b <= (write_a && same_addr) ? write_data_a : mem[addr_b];
        end
    end

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller over an external dual-port RAM: port A writes, port B reads.
// Latency: push to out_valid 3 cycles; at most one pop every 2 cycles.
// Backpressure: in_ready drops when 16 entries sit in RAM or during flush;
// out_data holds steady until out_ready.
// Ports: clk/reset/flush, in_* push side, out_* pop side, ram_level,
// ram_*_a write port, ram_*_b read port (unused directions tied low).
module dpram_fifo_ctrl
    import dpram_pkg::*;
#(
    parameter int DATA_W = DPRAM_DATA_W,
    parameter int ADDR_W = DPRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [ADDR_W:0]   ram_level,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic              ram_write_a,
    output logic [DATA_W-1:0] ram_write_data_a,
    output logic              ram_read_a,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic              ram_read_b,
    output logic              ram_write_b,
    output logic [DATA_W-1:0] ram_write_data_b,
    input  logic [DATA_W-1:0] ram_read_data_b
);

    localparam logic [ADDR_W:0] FULL_LEVEL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] PTR_ONE    = {{ADDR_W{1'b0}}, 1'b1};

    // MSB of each pointer is the wrap bit, so full and empty differ.
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    rd_state_t       state;
    logic            push;
    logic            pop;
    logic            rd_issue;

    assign ram_level = wr_ptr - rd_ptr;
    assign in_ready  = !reset && !flush && (ram_level != FULL_LEVEL);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Reads only go out with ram_level > 0, so the read address always
    // trails the write address and the two ports never collide.
    assign rd_issue = !reset && !flush && (ram_level != '0) &&
                      ((state == ST_IDLE) || ((state == ST_HOLD) && pop));

    assign ram_addr_a       = wr_ptr[ADDR_W-1:0];
    assign ram_write_a      = push;
    assign ram_write_data_a = in_data;
    assign ram_read_a       = 1'b0;

    assign ram_addr_b       = rd_ptr[ADDR_W-1:0];
    assign ram_read_b       = rd_issue;
    assign ram_write_b      = 1'b0;
    assign ram_write_data_b = '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            // Returning to IDLE drops any read already in flight.
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            state     <= ST_IDLE;
            out_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case (state)
                ST_IDLE: begin
                    if (rd_issue) begin
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    out_data  <= ram_read_data_b;
                    out_valid <= 1'b1;
                    state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (pop) begin
                        out_valid <= 1'b0;
                        state     <= rd_issue ? ST_FETCH : ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
module tb_dpram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [4:0] ram_level;
    logic [3:0] ram_addr_a;
    logic       ram_write_a;
    logic [7:0] ram_write_data_a;
    logic       ram_read_a;
    logic [3:0] ram_addr_b;
    logic       ram_read_b;
    logic       ram_write_b;
    logic [7:0] ram_write_data_b;
    logic [7:0] ram_read_data_b;

    logic       w_in_ready;
    logic       w_out_valid;
    logic [7:0] w_out_data;
    logic [4:0] w_ram_level;
    logic       w_ram_conflict;

    int n_chk  = 0;
    int n_fail = 0;
    int n_coll = 0;
    int n_wconf = 0;
    int exp_v;
    int n_push;
    logic pushed;

    logic [7:0] mem [16];

    always #5 clk = ~clk;

    dpram_fifo_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_ready        (out_ready),
        .ram_level        (ram_level),
        .ram_addr_a       (ram_addr_a),
        .ram_write_a      (ram_write_a),
        .ram_write_data_a (ram_write_data_a),
        .ram_read_a       (ram_read_a),
        .ram_addr_b       (ram_addr_b),
        .ram_read_b       (ram_read_b),
        .ram_write_b      (ram_write_b),
        .ram_write_data_b (ram_write_data_b),
        .ram_read_data_b  (ram_read_data_b)
    );

    dpram_fifo #(.DATA_W(8), .ADDR_W(4)) u_wrap (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (w_in_ready),
        .out_valid    (w_out_valid),
        .out_data     (w_out_data),
        .out_ready    (out_ready),
        .ram_level    (w_ram_level),
        .ram_conflict (w_ram_conflict)
    );

    // Simple RAM model for the bare controller: registered read.
    always @(posedge clk) begin
        if (ram_write_a) mem[ram_addr_a] <= ram_write_data_a;
        if (ram_read_b) ram_read_data_b <= mem[ram_addr_b];
    end

    always @(negedge clk) begin
        if (ram_write_a && ram_read_b && (ram_addr_a == ram_addr_b)) n_coll++;
        if (w_ram_conflict) n_wconf++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_level", ram_level, 0);
        chk("rst_write_a", ram_write_a, 0);
        chk("rst_read_b", ram_read_b, 0);
        chk("rst_w_out_valid", w_out_valid, 0);
        reset = 1'b0;
        #1;
        chk("in_ready_after_rst", in_ready, 1);
        chk("w_in_ready_after_rst", w_in_ready, 1);
        chk("tie_read_a", ram_read_a, 0);
        chk("tie_write_b", ram_write_b, 0);
        chk("tie_wdata_b", ram_write_data_b, 0);
        tick();

        // A5, 3C through an empty queue
        in_valid = 1'b1; in_data = 8'hA5;
        #1;
        chk("push_a5_we", ram_write_a, 1);
        chk("push_a5_addr", ram_addr_a, 0);
        chk("push_a5_wdata", ram_write_data_a, 8'hA5);
        tick();
        in_data = 8'h3C;
        #1;
        chk("push_3c_addr", ram_addr_a, 1);
        chk("first_read_issue", ram_read_b, 1);
        chk("first_read_addr", ram_addr_b, 0);
        tick();
        in_valid = 1'b0;
        chk("ov_not_early", out_valid, 0);
        tick();
        chk("ov_lat3", out_valid, 1);
        chk("head_a5", out_data, 8'hA5);
        chk("w_head_a5", w_out_data, 8'hA5);
        chk("level_1", ram_level, 1);
        out_ready = 1'b1;
        #1;
        chk("hold_pop_issue", ram_read_b, 1);
        chk("hold_pop_addr", ram_addr_b, 1);
        tick();
        chk("fetch_ov_low", out_valid, 0);
        tick();
        chk("head_3c", out_data, 8'h3C);
        chk("level_0", ram_level, 0);
        tick();
        out_ready = 1'b0;
        chk("idle_ov", out_valid, 0);
        chk("idle_level", ram_level, 0);

        // fill with 00..0F while stalled, then a 17th push
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 8'(i);
            tick();
        end
        in_data = 8'h10;
        #1;
        chk("fill_ov", out_valid, 1);
        chk("fill_head", out_data, 8'h00);
        chk("fill_level15", ram_level, 15);
        chk("fill_in_ready", in_ready, 1);
        tick();
        chk("full_level16", ram_level, 16);
        chk("w_full_level16", w_ram_level, 16);
        chk("full_in_ready", in_ready, 0);
        chk("full_no_write", ram_write_a, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        exp_v = 0;
        for (int c = 0; c < 100 && exp_v < 17; c++) begin
            if (out_valid) begin
                chk("drain_order", out_data, exp_v);
                exp_v++;
            end
            tick();
        end
        chk("drain_count", exp_v, 17);
        chk("drain_empty", ram_level, 0);

        // streaming with pointer wrap
        in_valid = 1'b1; in_data = 8'h40; exp_v = 8'h40; n_push = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) begin
                chk("stream_order", out_data, exp_v);
                exp_v++;
            end
            pushed = in_ready;
            tick();
            if (pushed) begin
                in_data = in_data + 8'h01;
                n_push++;
            end
        end
        in_valid = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (out_valid) begin
                chk("stream_order", out_data, exp_v);
                exp_v++;
            end
            tick();
        end
        chk("stream_total", exp_v, 8'h40 + n_push);
        chk("stream_empty", ram_level, 0);

        // flush while the first read is in flight
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h11;
        tick();
        in_data = 8'h22;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        chk("flush_ov", out_valid, 0);
        chk("flush_level", ram_level, 0);
        repeat (3) tick();
        chk("flush_no_stale", out_valid, 0);
        in_valid = 1'b1; in_data = 8'h77;
        tick();
        in_valid = 1'b0;
        tick();
        chk("p77_not_early", out_valid, 0);
        tick();
        chk("p77_ov", out_valid, 1);
        chk("p77_data", out_data, 8'h77);
        chk("w_p77_data", w_out_data, 8'h77);

        // simultaneous push and read issue at level 5
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'h81 + 8'(i);
            tick();
        end
        in_data = 8'h86; out_ready = 1'b1;
        #1;
        chk("both_level5", ram_level, 5);
        chk("both_we", ram_write_a, 1);
        chk("both_re", ram_read_b, 1);
        chk("both_addr_a", ram_addr_a, 6);
        chk("both_addr_b", ram_addr_b, 1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("both_level_kept", ram_level, 5);

        // async reset in HOLD
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b1; in_data = 8'hC3;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        chk("c3_ov", out_valid, 1);
        chk("c3_data", out_data, 8'hC3);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_ov", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_level", ram_level, 0);
        chk("w_arst_ov", w_out_valid, 0);
        chk("w_arst_data", w_out_data, 0);
        reset = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1);

        chk("no_collision", n_coll, 0);
        chk("w_no_conflict", n_wconf, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
